// File: rtl/fpu_packoutput_if.sv
// rtl/fpu_packoutput_if.sv - configuration package and handshake interface for fpu_packoutput
//
// fpu_packoutput_pkg : cvw_t configuration record (FLEN/NE/NF/BIAS and per-format
//                      Q_/D_/S_/H_ LEN/NE/NF/BIAS), DS_CFG = double+single setup.
// fpu_packoutput_if  : operand side  InValid/InReady, Fmt, Sgn, Exp, Man, NaN, Inf, Zero
//                      result side   OutValid/OutReady, Res, Overflow, Underflow, Inexact
//                      master = producer/consumer, slave = fpu_packoutput.

package fpu_packoutput_pkg;
    typedef struct packed {
        int FLEN;   int NE;     int NF;     int FMTBITS; int FPSIZES; int BIAS;
        int Q_LEN;  int Q_NE;   int Q_NF;   int Q_BIAS;
        int D_LEN;  int D_NE;   int D_NF;   int D_BIAS;
        int S_LEN;  int S_NE;   int S_NF;   int S_BIAS;
        int H_LEN;  int H_NE;   int H_NF;   int H_BIAS;
    } cvw_t;

    localparam cvw_t DS_CFG = '{
        FLEN: 64, NE: 11, NF: 52, FMTBITS: 2, FPSIZES: 2, BIAS: 1023,
        Q_LEN: 128, Q_NE: 15, Q_NF: 112, Q_BIAS: 16383,
        D_LEN: 64,  D_NE: 11, D_NF: 52,  D_BIAS: 1023,
        S_LEN: 32,  S_NE: 8,  S_NF: 23,  S_BIAS: 127,
        H_LEN: 16,  H_NE: 5,  H_NF: 10,  H_BIAS: 15
    };
endpackage

interface fpu_packoutput_if #(parameter fpu_packoutput_pkg::cvw_t P = fpu_packoutput_pkg::DS_CFG);
    logic                  InValid;
    logic                  InReady;
    logic [P.FMTBITS-1:0]  Fmt;
    logic                  Sgn;
    logic [P.NE+1:0]       Exp;
    logic [P.NF:0]         Man;
    logic                  NaN;
    logic                  Inf;
    logic                  Zero;
    logic                  OutValid;
    logic                  OutReady;
    logic [P.FLEN-1:0]     Res;
    logic                  Overflow;
    logic                  Underflow;
    logic                  Inexact;

    modport master (
        output InValid, Fmt, Sgn, Exp, Man, NaN, Inf, Zero, OutReady,
        input  InReady, OutValid, Res, Overflow, Underflow, Inexact
    );
    modport slave (
        input  InValid, Fmt, Sgn, Exp, Man, NaN, Inf, Zero, OutReady,
        output InReady, OutValid, Res, Overflow, Underflow, Inexact
    );
endinterface

// File: rtl/fpu_packoutput.sv
// rtl/fpu_packoutput.sv - pack unpacked FPU result into NaN-boxed register format
//
// Ports: clk, reset (sync, active high), bus (fpu_packoutput_if.slave).
// Rebiases the exponent to the target format, saturates to infinity on overflow,
// denormalizes tiny results one bit per cycle and NaN-boxes narrow formats.
// Optional macro FPACK_FLUSH_SUBNORM_EN: tiny results flush to signed zero in one
// cycle and the serial shifter is not built.

module fpu_packoutput import fpu_packoutput_pkg::*; #(
    parameter cvw_t P = DS_CFG
) (
    input  logic          clk,
    input  logic          reset,
    fpu_packoutput_if.slave bus
);
    localparam int FLEN = P.FLEN;
    localparam int NF   = P.NF;
    localparam int EW   = P.NE + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd2;
`ifndef FPACK_FLUSH_SUBNORM_EN
    localparam logic [1:0] SHIFT = 2'd1;
    localparam int CW = $clog2(NF + 3) + 1;
`endif

    logic [1:0]        state;
    logic [FLEN-1:0]   res_r;
    logic              ov_r, uf_r, ix_r;

    logic [1:0]        fmt_sel;
    int                f_len, f_ne, f_nf, f_bias;
    logic signed [EW-1:0] texp, emax;
    logic [FLEN-1:0]   emax_field;
    logic [NF-1:0]     lowmask;
    logic              tiny;
    logic [FLEN-1:0]   res_n;
    logic              ov_n, uf_n, ix_n, go_shift;

`ifndef FPACK_FLUSH_SUBNORM_EN
    logic [1:0]        fmt_r;
    logic              sgn_r;
    logic [NF:0]       man_r;
    logic              sticky_r;
    logic [CW-1:0]     cnt;
    logic [EW:0]       sh_full;
    logic [CW-1:0]     sh;
    logic [NF:0]       man_sh;
    logic              sticky_sh;
    logic [FLEN-1:0]   res_d;
    logic              ix_d;

    // While busy the bus operand may change, so the format comes from the capture.
    assign fmt_sel = (state == IDLE) ? 2'(bus.Fmt) : fmt_r;
`else
    assign fmt_sel = 2'(bus.Fmt);
`endif

    // Assemble sign | exponent field | top nf_f bits of f, with ones above len.
    function automatic logic [FLEN-1:0] pack(input logic s, input logic [FLEN-1:0] e,
                                             input logic [NF-1:0] f, input int len,
                                             input int nf_f);
        logic [FLEN-1:0] frac;
        frac = {{(FLEN-NF){1'b0}}, f} >> (NF - nf_f);
        return ({FLEN{1'b1}} << len) | (FLEN'(s) << (len - 1)) | (e << nf_f) | frac;
    endfunction

    always_comb begin
        case (fmt_sel)
            2'b11:   begin f_len = P.Q_LEN; f_ne = P.Q_NE; f_nf = P.Q_NF; f_bias = P.Q_BIAS; end
            2'b01:   begin f_len = P.D_LEN; f_ne = P.D_NE; f_nf = P.D_NF; f_bias = P.D_BIAS; end
            2'b10:   begin f_len = P.H_LEN; f_ne = P.H_NE; f_nf = P.H_NF; f_bias = P.H_BIAS; end
            default: begin f_len = P.S_LEN; f_ne = P.S_NE; f_nf = P.S_NF; f_bias = P.S_BIAS; end
        endcase
    end

    assign texp       = $signed(bus.Exp) - EW'(P.BIAS - f_bias);
    assign emax       = EW'((1 << f_ne) - 1);
    assign emax_field = FLEN'((1 << f_ne) - 1);
    assign lowmask    = ~({NF{1'b1}} << (NF - f_nf));
    assign tiny       = texp[EW-1] | (texp == '0);

    // Result for the single-cycle paths, decided straight from the bus operand.
    always_comb begin
        res_n    = '0;
        ov_n     = 1'b0;
        uf_n     = 1'b0;
        ix_n     = 1'b0;
        go_shift = 1'b0;
        if (bus.NaN) begin
            res_n = pack(1'b0, emax_field, {1'b1, {(NF-1){1'b0}}}, f_len, f_nf);
        end else if (bus.Inf) begin
            res_n = pack(bus.Sgn, emax_field, '0, f_len, f_nf);
        end else if (bus.Zero) begin
            res_n = pack(bus.Sgn, '0, '0, f_len, f_nf);
        end else if (texp >= emax) begin
            res_n = pack(bus.Sgn, emax_field, '0, f_len, f_nf);
            ov_n  = 1'b1;
            ix_n  = 1'b1;
        end else if (tiny) begin
`ifdef FPACK_FLUSH_SUBNORM_EN
            res_n = pack(bus.Sgn, '0, '0, f_len, f_nf);
            uf_n  = 1'b1;
            ix_n  = 1'b1;
`else
            go_shift = 1'b1;
`endif
        end else begin
            res_n = pack(bus.Sgn, FLEN'(texp), bus.Man[NF-1:0], f_len, f_nf);
            ix_n  = |(bus.Man[NF-1:0] & lowmask);
        end
    end

`ifndef FPACK_FLUSH_SUBNORM_EN
    // Shift count 1 - texp, saturated: past nf_f+2 bits everything is sticky anyway.
    always_comb begin
        sh_full = (EW+1)'(1) - {texp[EW-1], texp};
        if (sh_full > (EW+1)'(f_nf + 2))
            sh = CW'(f_nf + 2);
        else
            sh = sh_full[CW-1:0];
    end

    assign man_sh    = man_r >> 1;
    assign sticky_sh = sticky_r | man_r[0];
    assign res_d     = pack(sgn_r, '0, man_sh[NF-1:0], f_len, f_nf);
    assign ix_d      = sticky_sh | (|(man_sh[NF-1:0] & lowmask));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            res_r    <= '0;
            ov_r     <= 1'b0;
            uf_r     <= 1'b0;
            ix_r     <= 1'b0;
`ifndef FPACK_FLUSH_SUBNORM_EN
            fmt_r    <= '0;
            sgn_r    <= 1'b0;
            man_r    <= '0;
            sticky_r <= 1'b0;
            cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.InValid) begin
                    res_r <= res_n;
                    ov_r  <= ov_n;
                    uf_r  <= uf_n;
                    ix_r  <= ix_n;
`ifndef FPACK_FLUSH_SUBNORM_EN
                    fmt_r    <= 2'(bus.Fmt);
                    sgn_r    <= bus.Sgn;
                    man_r    <= bus.Man;
                    sticky_r <= 1'b0;
                    cnt      <= sh;
                    state    <= go_shift ? SHIFT : HOLD;
`else
                    state <= go_shift ? IDLE : HOLD;
`endif
                end
`ifndef FPACK_FLUSH_SUBNORM_EN
                SHIFT: begin
                    man_r    <= man_sh;
                    sticky_r <= sticky_sh;
                    cnt      <= cnt - CW'(1);
                    // Last shift: the value leaving the shifter this cycle is final.
                    if (cnt == CW'(1)) begin
                        res_r <= res_d;
                        ov_r  <= 1'b0;
                        uf_r  <= ix_d;
                        ix_r  <= ix_d;
                        state <= HOLD;
                    end
                end
`endif
                HOLD: if (bus.OutReady) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.InReady   = (state == IDLE) & ~reset;
    assign bus.OutValid  = (state == HOLD);
    assign bus.Res       = res_r;
    assign bus.Overflow  = ov_r;
    assign bus.Underflow = uf_r;
    assign bus.Inexact   = ix_r;
endmodule

// File: tb/tb_fpu_packoutput.sv
// tb/tb_fpu_packoutput.sv - self-checking bench for fpu_packoutput (double+single config)
module tb_fpu_packoutput;
    import fpu_packoutput_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fpu_packoutput_if #(.P(DS_CFG)) bus ();
    fpu_packoutput #(.P(DS_CFG)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [1:0]  fmt;
        logic        sgn;
        int          exp;
        logic [52:0] man;
        logic        nan, inf, zero;
        logic [63:0] res;
        logic [2:0]  flags;   // {Overflow, Underflow, Inexact}
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value-level packing from the format rules, no notion of cycles.
    function automatic vec_t model(input vec_t v);
        int nf, ne, bias, len, emax, te, sh, drop;
        longint unsigned m, kept, boxv, sgnb;
        logic lost, low;
        vec_t r;
        r = v;
        if (v.fmt == 2'b01) begin nf = 52; ne = 11; bias = 1023; len = 64; end
        else                begin nf = 23; ne = 8;  bias = 127;  len = 32; end
        emax = (1 << ne) - 1;
        te   = v.exp - (1023 - bias);
        drop = 52 - nf;
        boxv = (len == 64) ? 64'd0 : 64'hFFFFFFFF_00000000;
        sgnb = longint'(v.sgn) << (len - 1);
        m    = longint'(v.man);
        r.flags = 3'b000;
        r.lat   = 1;
        if (v.nan) r.res = boxv | (longint'(emax) << nf) | (64'd1 << (nf - 1));
        else if (v.inf) r.res = boxv | sgnb | (longint'(emax) << nf);
        else if (v.zero) r.res = boxv | sgnb;
        else if (te >= emax) begin
            r.res = boxv | sgnb | (longint'(emax) << nf);
            r.flags = 3'b101;
        end else if (te >= 1) begin
            r.res = boxv | sgnb | (longint'(te) << nf) | ((m & 64'h000F_FFFF_FFFF_FFFF) >> drop);
            r.flags = ((m % (64'd1 << drop)) != 0) ? 3'b001 : 3'b000;
        end else begin
`ifdef FPACK_FLUSH_SUBNORM_EN
            r.res = boxv | sgnb;
            r.flags = 3'b011;
`else
            sh   = (1 - te > nf + 2) ? nf + 2 : 1 - te;
            kept = m >> sh;
            lost = (m - (kept << sh)) != 0;
            low  = (kept % (64'd1 << drop)) != 0;
            r.res = boxv | sgnb | (kept >> drop);
            r.flags = (lost || low) ? 3'b011 : 3'b000;
            r.lat = 1 + sh;
`endif
        end
        return r;
    endfunction

    task automatic drive(input vec_t v);
        bus.Fmt  = v.fmt;
        bus.Sgn  = v.sgn;
        bus.Exp  = 13'(v.exp);
        bus.Man  = v.man;
        bus.NaN  = v.nan;
        bus.Inf  = v.inf;
        bus.Zero = v.zero;
    endtask

    // Called at a negedge; returns at a negedge with the block back in IDLE.
    task automatic run_op(input vec_t v, output logic [63:0] res, output logic [2:0] flags,
                          output int lat);
        int w = 0;
        while (!bus.InReady && w < 100) begin @(negedge clk); w++; end
        drive(v);
        bus.InValid = 1'b1;
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.OutValid && lat < 200);
        if (!bus.OutValid) lat = -1;
        res   = bus.Res;
        flags = {bus.Overflow, bus.Underflow, bus.Inexact};
        bus.OutReady = 1'b1;
        @(posedge clk);
        #1 bus.OutReady = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] res, held;
        logic [2:0]  flags;
        int          lat, seen;
        vec_t        v, e;

        bus.InValid = 1'b0; bus.OutReady = 1'b0;
        v = '{fmt: 2'b00, sgn: 1'b0, exp: 0, man: '0, nan: 1'b0, inf: 1'b0, zero: 1'b0,
              res: '0, flags: '0, lat: 0};
        drive(v);

        // Directed vectors: fmt sgn exp man nan inf zero | res flags latency
        vecs.push_back('{2'b00, 1'b0, 1023, 53'd1 << 52, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF3F800000, 3'b000, 1});
        vecs.push_back('{2'b01, 1'b1, 1024, 53'd1 << 52, 1'b0, 1'b0, 1'b0, 64'hC000000000000000, 3'b000, 1});
        vecs.push_back('{2'b00, 1'b0, 1023, (53'd1 << 52) | 53'd1, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF3F800000, 3'b001, 1});
        vecs.push_back('{2'b00, 1'b0, 1151, 53'd1 << 52, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF7F800000, 3'b101, 1});
        vecs.push_back('{2'b01, 1'b0, 1023, 53'd1 << 52, 1'b1, 1'b0, 1'b0, 64'h7FF8000000000000, 3'b000, 1});
        vecs.push_back('{2'b00, 1'b1, 1023, 53'd1 << 52, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFF7FC00000, 3'b000, 1});
        vecs.push_back('{2'b00, 1'b1, 5,    53'd1 << 52, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFF800000, 3'b000, 1});
        vecs.push_back('{2'b01, 1'b1, 3000, 53'd1 << 52, 1'b0, 1'b0, 1'b1, 64'h8000000000000000, 3'b000, 1});
        vecs.push_back('{2'b01, 1'b0, 2046, {53{1'b1}},  1'b0, 1'b0, 1'b0, 64'h7FEFFFFFFFFFFFFF, 3'b000, 1});
        vecs.push_back('{2'b00, 1'b0, 897,  53'd1 << 52, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF00800000, 3'b000, 1});
`ifdef FPACK_FLUSH_SUBNORM_EN
        vecs.push_back('{2'b00, 1'b0, 896,  53'd1 << 52, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF00000000, 3'b011, 1});
        vecs.push_back('{2'b00, 1'b0, 800,  53'd1 << 52, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF00000000, 3'b011, 1});
        vecs.push_back('{2'b01, 1'b0, 0,    53'd1 << 52, 1'b0, 1'b0, 1'b0, 64'h0000000000000000, 3'b011, 1});
        vecs.push_back('{2'b01, 1'b1, -60,  (53'd1 << 52) | 53'd1, 1'b0, 1'b0, 1'b0, 64'h8000000000000000, 3'b011, 1});
`else
        vecs.push_back('{2'b00, 1'b0, 896,  53'd1 << 52, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF00400000, 3'b000, 2});
        vecs.push_back('{2'b00, 1'b0, 800,  53'd1 << 52, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF00000000, 3'b011, 26});
        vecs.push_back('{2'b01, 1'b0, 0,    53'd1 << 52, 1'b0, 1'b0, 1'b0, 64'h0008000000000000, 3'b000, 2});
        vecs.push_back('{2'b01, 1'b1, -60,  (53'd1 << 52) | 53'd1, 1'b0, 1'b0, 1'b0, 64'h8000000000000000, 3'b011, 55});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_inready", 64'(bus.InReady), 64'd0);
        check("reset_outvalid", 64'(bus.OutValid), 64'd0);
        check("reset_res", bus.Res, 64'd0);
        check("reset_flags", 64'({bus.Overflow, bus.Underflow, bus.Inexact}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_inready", 64'(bus.InReady), 64'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i], res, flags, lat);
            check($sformatf("vec%0d_res", i), res, vecs[i].res);
            check($sformatf("vec%0d_flags", i), 64'(flags), 64'(vecs[i].flags));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
        end

        // NaN under backpressure
        v = '{fmt: 2'b00, sgn: 1'b1, exp: 1023, man: 53'd1 << 52, nan: 1'b1, inf: 1'b0,
              zero: 1'b0, res: '0, flags: '0, lat: 0};
        drive(v);
        bus.InValid = 1'b1;
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        @(negedge clk);
        check("bp_outvalid", 64'(bus.OutValid), 64'd1);
        held = bus.Res;
        check("bp_res", held, 64'hFFFFFFFF7FC00000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_res_stable", bus.Res, 64'hFFFFFFFF7FC00000);
            check("bp_inready_low", 64'(bus.InReady), 64'd0);
            check("bp_flags", 64'({bus.Overflow, bus.Underflow, bus.Inexact}), 64'd0);
        end
        bus.OutReady = 1'b1;
        @(posedge clk);
        #1 bus.OutReady = 1'b0;
        @(negedge clk);
        check("bp_idle_outvalid", 64'(bus.OutValid), 64'd0);
        check("bp_idle_inready", 64'(bus.InReady), 64'd1);

        // Reset in the middle of a long denormalization
        v = '{fmt: 2'b00, sgn: 1'b0, exp: 800, man: 53'd1 << 52, nan: 1'b0, inf: 1'b0,
              zero: 1'b0, res: '0, flags: '0, lat: 0};
        drive(v);
        bus.InValid = 1'b1;
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_inready", 64'(bus.InReady), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_outvalid", 64'(bus.OutValid), 64'd0);
        check("midrst_inready_after", 64'(bus.InReady), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.OutValid) seen = 1;
        end
        check("midrst_no_result", 64'(seen), 64'd0);

        // Randomized operands against the reference
        for (int n = 0; n < 300; n++) begin
            v.fmt  = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            v.sgn  = 1'($urandom);
            v.man  = {1'b1, 20'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) v.man[28:0] = '0;
            if (v.fmt == 2'b01) v.exp = $urandom_range(0, 2200) - 100;
            else                v.exp = $urandom_range(840, 1160);
            v.nan  = ($urandom_range(0, 15) == 0);
            v.inf  = ($urandom_range(0, 15) == 0);
            v.zero = ($urandom_range(0, 15) == 0);
            e = model(v);
            run_op(v, res, flags, lat);
            check($sformatf("rand%0d_res", n), res, e.res);
            check($sformatf("rand%0d_flags", n), 64'(flags), 64'(e.flags));
            check($sformatf("rand%0d_lat", n), 64'(lat), 64'(e.lat));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
